// File: rtl/counter_mod_n.sv
// counter_mod_n: modulo-MOD up/down counter with enable, clamped parallel load,
// wrap or saturate end behaviour, terminal-count, wrap pulse and sticky overflow.
// All state updates on the falling edge of clk; clr is an asynchronous active-low reset.
//
// Ports:
//   clk      in   clock (falling edge active)
//   clr      in   asynchronous reset, active low
//   en       in   count enable
//   up_dn    in   direction: 1 = up, 0 = down
//   load     in   synchronous parallel load (beats en)
//   load_val in   load value, clamped to MOD-1
//   ovf_clr  in   synchronous clear of ovf (a same-cycle set wins)
//   count    out  registered count, 0..MOD-1
//   tc       out  combinational terminal count for the current direction, gated by en
//   wrap     out  registered one-cycle pulse after a wrap or blocked saturation step
//   ovf      out  sticky overflow flag
module counter_mod_n #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MOD   = 60,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  generate
    if (MOD < 2 || 64'(MOD) > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("counter_mod_n: MOD must lie in 2..2**WIDTH");
    end
  endgenerate

  // Only the end value is held as a WIDTH-bit constant; MOD itself may not fit.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  logic             at_end;
  logic             end_evt;
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    at_end = up_dn ? (count == LAST) : (count == '0);
    tc     = en & at_end;
  end

  always_comb begin
    count_nxt = count;
    end_evt   = 1'b0;
    if (load) begin
      count_nxt = (load_val > LAST) ? LAST : load_val;
    end else if (en) begin
      if (at_end) begin
        end_evt = 1'b1;
        if (!SAT) begin
          count_nxt = up_dn ? '0 : LAST;
        end
      end else begin
        count_nxt = up_dn ? count + 1'b1 : count - 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= end_evt;
      ovf   <= end_evt | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: three instances share one stimulus stream, namely
// a wrapping counter and a saturating counter at modulus 60 plus a wrapping
// counter at modulus 64. A reference model predicts each instance's outputs
// and queues them; a monitor compares at the rising edge.
module tb_counter_mod_n;

  typedef struct packed {
    logic [5:0] count;
    logic       wrap;
    logic       ovf;
    logic       tc;
  } exp_t;

  logic       clk = 1'b1;
  logic       clr = 1'b0;
  logic       en = 1'b1;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [5:0] load_val = '0;
  logic       ovf_clr = 1'b0;

  logic [5:0] cnt [3];
  logic       tcs [3];
  logic       wrs [3];
  logic       ovs [3];

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q [3][$];

  int mods [3] = '{60, 60, 64};
  int sats [3] = '{0, 1, 0};
  int mc [3];
  int mw [3];
  int mo [3];

  always #5 clk = ~clk;

  counter_mod_n #(.WIDTH(6), .MOD(60), .SAT(1'b0)) dut_a (
    .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt[0]), .tc(tcs[0]), .wrap(wrs[0]), .ovf(ovs[0]));
  counter_mod_n #(.WIDTH(6), .MOD(60), .SAT(1'b1)) dut_b (
    .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt[1]), .tc(tcs[1]), .wrap(wrs[1]), .ovf(ovs[1]));
  counter_mod_n #(.WIDTH(6), .MOD(64), .SAT(1'b0)) dut_c (
    .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt[2]), .tc(tcs[2]), .wrap(wrs[2]), .ovf(ovs[2]));

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Reference model: apply one falling edge with the current inputs, queue
  // the outputs expected at the following rising edge.
  task automatic model_edge(input int i);
    int   last = mods[i] - 1;
    int   ev = 0;
    exp_t e;
    if (!clr) begin
      mc[i] = 0; mw[i] = 0; mo[i] = 0;
    end else if (load) begin
      mc[i] = (int'(load_val) > last) ? last : int'(load_val);
      mw[i] = 0;
      if (ovf_clr) mo[i] = 0;
    end else begin
      if (en) begin
        if (up_dn) begin
          if (mc[i] == last) begin ev = 1; if (sats[i] == 0) mc[i] = 0; end
          else mc[i] = mc[i] + 1;
        end else begin
          if (mc[i] == 0) begin ev = 1; if (sats[i] == 0) mc[i] = last; end
          else mc[i] = mc[i] - 1;
        end
      end
      mw[i] = ev;
      if (ev != 0) mo[i] = 1;
      else if (ovf_clr) mo[i] = 0;
    end
    e.count = 6'(mc[i]);
    e.wrap  = (mw[i] != 0);
    e.ovf   = (mo[i] != 0);
    e.tc    = en & (up_dn ? (mc[i] == last) : (mc[i] == 0));
    q[i].push_back(e);
  endtask

  task automatic step(input logic c, input logic e, input logic u, input logic l,
                      input int lv, input logic oc);
    @(posedge clk);
    #1;
    clr = c; en = e; up_dn = u; load = l; load_val = 6'(lv); ovf_clr = oc;
    for (int i = 0; i < 3; i++) model_edge(i);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() > 0) begin
        exp_t x;
        x = q[i].pop_front();
        chk("count", i, int'(cnt[i]), int'(x.count));
        chk("wrap",  i, int'(wrs[i]), int'(x.wrap));
        chk("ovf",   i, int'(ovs[i]), int'(x.ovf));
        chk("tc",    i, int'(tcs[i]), int'(x.tc));
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin mc[i] = 0; mw[i] = 0; mo[i] = 0; end

    // Reset held with en=1 for three edges, then released.
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_count", i, int'(cnt[i]), 0);
      chk("rst_wrap",  i, int'(wrs[i]), 0);
      chk("rst_ovf",   i, int'(ovs[i]), 0);
    end
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Full up cycle from 0, then clear ovf.
    step(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    repeat (66) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Load 2 and count down through 0; clamp of an out-of-range load.
    step(1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 63, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Saturation from 57, then reversal with no bubble.
    step(1'b1, 1'b0, 1'b1, 1'b1, 57, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Load beats en at the end value; ovf_clr loses to a same-cycle wrap.
    step(1'b1, 1'b0, 1'b1, 1'b1, 59, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 10, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 59, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Hold with en low at an end value (tc must stay low).
    step(1'b1, 1'b0, 1'b1, 1'b1, 59, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Randomised traffic.
    repeat (500) begin
      step(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 63)),
           ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-count, observed before the next falling edge.
    step(1'b1, 1'b0, 1'b1, 1'b1, 37, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_count", i, int'(cnt[i]), 0);
      chk("async_wrap",  i, int'(wrs[i]), 0);
      chk("async_ovf",   i, int'(ovs[i]), 0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 8; k++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
      @(posedge clk);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain dut%0d: got %0d pending expected 0", i, q[i].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_mod_n.md
Name: counter_mod_n

Overview:
- Parametrised modulo-M up/down counter. Successor to the team's free-running N-bit clear/count counter.
- Adds the following over that counter:
  - programmable modulus
  - count direction
  - count enable
  - parallel load
  - wrap or saturate mode
  - terminal-count, wrap-pulse and sticky overflow flags
- Used as the base timer/divider for timing chains, for example seconds and minutes stages cascaded through tc.

Parameters:
- WIDTH, 6: counter width in bits; count is WIDTH bits.
- MOD, 60: modulus. Legal range 2..2**WIDTH. Count range 0..MOD-1. An illegal value stops elaboration via a generate-time check.
- SAT, 0: end-of-range behaviour. 0 = wrap. 1 = saturate (hold at the end value).

Ports:
- clk, input, 1: clock. All registers update on the falling edge of clk (codebase convention).
- clr, input, 1: asynchronous, active-low reset.
- en, input, 1: count enable. When low, count holds.
- up_dn, input, 1: direction. 1 = up, 0 = down.
- load, input, 1: synchronous parallel load.
- load_val, input, WIDTH: value for load.
- ovf_clr, input, 1: synchronous clear of ovf.
- count, output, WIDTH: current count, registered.
- tc, output, 1: terminal count, combinational. High when en is high and count is at the end value for the current direction.
- wrap, output, 1: registered one-cycle pulse. High in the cycle after a wrap or a blocked saturation step.
- ovf, output, 1: sticky flag. Set on a wrap or a blocked saturation step.

Behaviour:
- Reset: clr low asynchronously forces count=0, wrap=0, ovf=0, independent of clk. The reset has priority over every input. Deassertion takes effect at the next falling edge.
- Priority at each falling edge (clr high): load > en > hold.
- load=1:
  - count <= load_val if load_val < MOD, otherwise MOD-1 (clamped).
  - wrap <= 0. ovf unaffected except by ovf_clr.
  - en and up_dn are ignored.
- en=1, up_dn=1:
  - count < MOD-1: count+1.
  - count == MOD-1, SAT=0: count <= 0, wrap <= 1, ovf <= 1.
  - count == MOD-1, SAT=1: count holds, wrap <= 1, ovf <= 1.
- en=1, up_dn=0:
  - count > 0: count-1.
  - count == 0, SAT=0: count <= MOD-1, wrap <= 1, ovf <= 1.
  - count == 0, SAT=1: count holds at 0, wrap <= 1, ovf <= 1.
- en=0, load=0: count holds, wrap <= 0.
- wrap is a single-cycle pulse. It deasserts at the next edge unless another end event occurs. Consecutive end events in SAT=1 keep wrap high.
- tc = en & (up_dn ? count==MOD-1 : count==0). Combinational, no latency; intended as the en input of the next cascaded stage.
- ovf_clr=1 clears ovf at the edge. If a set event occurs in the same cycle, set wins and ovf stays 1.
- Direction change mid-count takes effect at the next edge with no bubble. Example: count=5, up_dn goes 1→0, next count=4.
- Arithmetic: comparisons are on WIDTH bits. When MOD==2**WIDTH, natural binary wrap must yield identical results; the implementation must not form MOD as a WIDTH-bit constant.
- A mid-count clr low returns every output to its reset value within the same cycle, with no glitch to an intermediate count value.

Test Plan:
- Reset (WIDTH=6, MOD=60, SAT=0): clr low for 3 edges with en=1, then clr high → count=0, wrap=0, ovf=0 throughout reset; count=1 after the first falling edge.
- Up wrap: en=1, up_dn=1, 60 edges from 0 → count 0..59 then 0. tc high only while count=59. wrap high for exactly one cycle after 59→0. ovf=1 and stays 1. ovf_clr for one edge → ovf=0.
- Down wrap and load clamp:
  - load with load_val=2, then count down → 2,1,0,59. wrap pulses after 0→59.
  - load_val=63 → count=59 (clamped).
- Saturate (SAT=1): count up from 57 → 58, 59, 59, 59. wrap stays high while blocked. Then up_dn=0 → 58.
- Priority and simultaneity:
  - load=1 with en=1 at count=59 → load wins and wrap=0.
  - ovf_clr=1 in the same cycle as a wrap → ovf stays 1.
  - en=0 → count holds and tc=0.
- Async reset mid-count: at count=37, drive clr low between clock edges → count=0 immediately, before the next edge. Repeat with MOD=64 and WIDTH=6 to check the 63→0 wrap.
